// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter states and default timing.
// Cycle counts assume the 10 MHz keyboard-port clock.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    SHIFT,
    ACK,
    WAIT_IDLE,
    DONE,
    ERROR
  } ps2_state_e;

  localparam int INHIBIT_DEF = 1000;
  localparam int TIMEOUT_DEF = 150000;
  localparam int FRAME_LEN   = 11;

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for the PS/2 pins plus a falling-edge
// strobe on the synchronized clock; shared with the receive path.
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_dat,
  output logic clk_sync,
  output logic dat_sync,
  output logic fall
);

  logic clk_meta;
  logic dat_meta;
  logic clk_prev;

  // Idle bus level is high, so reset to 1 to avoid a fake edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_meta <= 1'b1;
      clk_sync <= 1'b1;
      clk_prev <= 1'b1;
      dat_meta <= 1'b1;
      dat_sync <= 1'b1;
    end else begin
      clk_meta <= ps2_clk;
      clk_sync <= clk_meta;
      clk_prev <= clk_sync;
      dat_meta <= ps2_dat;
      dat_sync <= dat_meta;
    end
  end

  assign fall = clk_prev & ~clk_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter with ACK check and a
// whole-transaction timeout; drives the lines via output enables.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = INHIBIT_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic [7:0] iData,
  input  logic       iSend,
  output logic       oBusy,
  output logic       oDone,
  output logic       oError,
  input  logic       iPs2Clk,
  input  logic       iPs2Dat,
  output logic       oPs2ClkOe,
  output logic       oPs2DatOe
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  ps2_state_e state;
  logic [8:0] sr;
  logic [3:0] bits;
  logic [TW-1:0] tmo;
  logic clk_sync;
  logic dat_sync;
  logic fall;

  ps2_line_sync u_sync (
    .clk      (iClk),
    .rst      (iRst),
    .ps2_clk  (iPs2Clk),
    .ps2_dat  (iPs2Dat),
    .clk_sync (clk_sync),
    .dat_sync (dat_sync),
    .fall     (fall)
  );

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state     <= IDLE;
      sr        <= '0;
      bits      <= '0;
      tmo       <= '0;
      oBusy     <= 1'b0;
      oDone     <= 1'b0;
      oError    <= 1'b0;
      oPs2ClkOe <= 1'b0;
      oPs2DatOe <= 1'b0;
    end else begin
      oDone  <= 1'b0;
      oError <= 1'b0;
      if (oBusy && tmo != TW'(TIMEOUT_CYCLES))
        tmo <= tmo + 1'b1;
      // oBusy is high exactly in the states the timeout guards.
      if (oBusy && tmo == TW'(TIMEOUT_CYCLES - 1)) begin
        state     <= ERROR;
        oBusy     <= 1'b0;
        oError    <= 1'b1;
        oPs2ClkOe <= 1'b0;
        oPs2DatOe <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (iSend) begin
              state     <= INHIBIT;
              sr        <= {~^iData, iData};
              bits      <= '0;
              tmo       <= '0;
              oBusy     <= 1'b1;
              oPs2ClkOe <= 1'b1;
            end
          end
          INHIBIT: begin
            if (tmo == TW'(INHIBIT_CYCLES - 2))
              oPs2DatOe <= 1'b1;
            if (tmo == TW'(INHIBIT_CYCLES - 1)) begin
              oPs2ClkOe <= 1'b0;
              state     <= RTS;
            end
          end
          RTS: state <= SHIFT;
          SHIFT: begin
            if (fall) begin
              bits <= bits + 1'b1;
              if (bits == 4'(FRAME_LEN - 1)) begin
                state <= ACK;
              end else begin
                // Ones shift in, so the tenth edge releases the stop bit.
                oPs2DatOe <= ~sr[0];
                sr        <= {1'b1, sr[8:1]};
              end
            end
          end
          ACK: begin
            oPs2DatOe <= 1'b0;
            if (dat_sync) begin
              state  <= ERROR;
              oBusy  <= 1'b0;
              oError <= 1'b1;
            end else begin
              state <= WAIT_IDLE;
            end
          end
          WAIT_IDLE: begin
            if (clk_sync && dat_sync) begin
              state <= DONE;
              oBusy <= 1'b0;
              oDone <= 1'b1;
            end
          end
          DONE:    state <= IDLE;
          ERROR:   state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
